// File: rtl/complex_pkg.sv
// Shared complex-sample types and helpers for the complex datapath blocks.
// Samples travel as 64-bit words laid out {re[31:0], im[31:0]}.
package complex_pkg;

    localparam int CPLX_W = 64;
    localparam int PART_W = 32;

    typedef struct packed {
        logic [PART_W-1:0] re;
        logic [PART_W-1:0] im;
    } complex_t;

    function automatic logic [CPLX_W-1:0] pack_cplx(input complex_t c);
        return {c.re, c.im};
    endfunction

    function automatic complex_t unpack_cplx(input logic [CPLX_W-1:0] w);
        complex_t c;
        c.re = w[CPLX_W-1:PART_W];
        c.im = w[PART_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/complex_sync_fifo.sv
// Synchronous FIFO of complex samples with flush; head is zero when empty.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: full blocks pushes; a slot freed by a pop is usable only the next cycle.
module complex_sync_fifo
    import complex_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [CPLX_W-1:0] push_data,
    input  logic              pop,
    output logic [CPLX_W-1:0] head,
    output logic              vld,
    output logic              full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_OCC = (AW + 1)'(DEPTH);

    complex_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    assign vld     = ~empty;
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = empty ? '0 : pack_cplx(mem[rd_ptr]);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= unpack_cplx(push_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/complex_stream_demux.sv
// Routes each complex sample to out0 or out1 by in_sel; CDEMUX_STATS_EN adds beat counters.
// Latency: 1 cycle from input acceptance to outK_valid.
// Backpressure: in_ready tracks only the FIFO selected by in_sel, so a stalled consumer blocks only its own traffic.
module complex_stream_demux
    import complex_pkg::*;
#(
    parameter int DEPTH = 2
`ifdef CDEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [CPLX_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CPLX_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [CPLX_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready
`ifdef CDEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  out0_count,
    output logic [CNT_W-1:0]  out1_count
`endif
);

    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // in_sel is only meaningful with in_valid, so the combinational path is safe.
    assign in_ready = ~flush & (in_sel ? ~full1 : ~full0);
    assign push0    = in_valid & in_ready & ~in_sel;
    assign push1    = in_valid & in_ready &  in_sel;

    complex_sync_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .head      (out0_data),
        .vld       (out0_valid),
        .full      (full0)
    );

    complex_sync_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .head      (out1_data),
        .vld       (out1_valid),
        .full      (full1)
    );

`ifdef CDEMUX_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Pops in a flush cycle are discarded, so they are not counted as delivered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0_count <= '0;
            out1_count <= '0;
        end else begin
            if (out0_valid && out0_ready && !flush) begin
                out0_count <= out0_count + CNT_ONE;
            end
            if (out1_valid && out1_ready && !flush) begin
                out1_count <= out1_count + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_complex_stream_demux.sv
// Directed and randomized check of complex_stream_demux against a queue-based model.
module tb_complex_stream_demux;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [63:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [63:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [CNT_W-1:0] out0_count;
    logic [CNT_W-1:0] out1_count;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    complex_stream_demux #(
        .DEPTH (DEPTH)
`ifdef CDEMUX_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef CDEMUX_STATS_EN
        ,
        .out0_count (out0_count),
        .out1_count (out1_count)
`endif
    );

`ifndef CDEMUX_STATS_EN
    assign out0_count = '0;
    assign out1_count = '0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per output, plain counters for delivered beats.
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          mcnt0 = 0;
    int          mcnt1 = 0;
    bit          model_live = 0;

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            mcnt0 = 0;
            mcnt1 = 0;
            model_live = 1;
        end else if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            acc = in_valid && ((in_sel ? q1.size() : q0.size()) < DEPTH);
            if (out0_ready && q0.size() > 0) begin
                void'(q0.pop_front());
                mcnt0 = (mcnt0 + 1) % (1 << CNT_W);
            end
            if (out1_ready && q1.size() > 0) begin
                void'(q1.pop_front());
                mcnt1 = (mcnt1 + 1) % (1 << CNT_W);
            end
            if (acc) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("m_out0_valid", 64'(out0_valid), 64'(q0.size() > 0));
            chk("m_out1_valid", 64'(out1_valid), 64'(q1.size() > 0));
            chk("m_out0_data", out0_data, (q0.size() > 0) ? q0[0] : 64'h0);
            chk("m_out1_data", out1_data, (q1.size() > 0) ? q1[0] : 64'h0);
            chk("m_in_ready", 64'(in_ready),
                64'(!flush && ((in_sel ? q1.size() : q0.size()) < DEPTH)));
`ifdef CDEMUX_STATS_EN
            chk("m_out0_count", 64'(out0_count), 64'(mcnt0));
            chk("m_out1_count", 64'(out1_count), 64'(mcnt1));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] A  = 64'h00000001_00000002;
    localparam logic [63:0] B  = 64'h00000003_00000004;
    localparam logic [63:0] C1 = 64'h11111111_AAAAAAAA;
    localparam logic [63:0] C2 = 64'h22222222_BBBBBBBB;
    localparam logic [63:0] C3 = 64'h33333333_CCCCCCCC;
    localparam logic [63:0] D  = 64'hDDDDDDDD_00000001;
    localparam logic [63:0] E  = 64'hEEEEEEEE_00000002;
    localparam logic [63:0] F  = 64'hFFFFFFFF_00000003;

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 64'hDEAD_BEEF_DEAD_BEEF;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // Reset held with in_valid high
        repeat (3) step();
        chk("rst_out0_valid", 64'(out0_valid), 64'd0);
        chk("rst_out1_valid", 64'(out1_valid), 64'd0);
        chk("rst_out0_data", out0_data, 64'h0);
        chk("rst_out1_data", out1_data, 64'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Routing
        in_valid = 1'b1; in_sel = 1'b0; in_data = A;
        step();
        chk("route_out0_data", out0_data, A);
        chk("route_out1_valid", 64'(out1_valid), 64'd0);
        in_sel = 1'b1; in_data = B;
        step();
        chk("route_out0_nodup", 64'(out0_valid), 64'd0);
        chk("route_out1_data", out1_data, B);
        in_valid = 1'b0;
        step();
        chk("route_out1_nodup", 64'(out1_valid), 64'd0);

        // Back-pressure isolation on out0
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = C1;
        step();
        in_data = C2;
        step();
        in_data = C3;
        #1;
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        step();
        in_sel = 1'b1; in_data = D;
        #1;
        chk("bp_in_ready_sel1", 64'(in_ready), 64'd1);
        step();
        chk("bp_out1_data", out1_data, D);
        chk("bp_out0_head", out0_data, C1);

        // Full boundary: one pop, slot frees a cycle later
        out0_ready = 1'b1;
        in_sel = 1'b0; in_data = C3;
        #1;
        chk("full_in_ready_pop_cycle", 64'(in_ready), 64'd0);
        step();
        out0_ready = 1'b0;
        chk("full_in_ready_after", 64'(in_ready), 64'd1);
        chk("full_out0_head", out0_data, C2);
        step();
        in_valid = 1'b0;

        // Flush with FIFO0 holding 2, FIFO1 holding 1
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = E;
        step();
        chk("fl_pre_out1", out1_data, E);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out0_valid", 64'(out0_valid), 64'd0);
        chk("fl_out1_valid", 64'(out1_valid), 64'd0);
        out0_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = F;
        step();
        in_valid = 1'b0;
        chk("fl_post_push", out0_data, F);
        step();

        // Randomized traffic, including rare flushes and resets
        for (int i = 0; i < 4000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = {$urandom, $urandom};
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 40) == 0);
            rst_n      = ($urandom_range(0, 600) != 0);
            step();
        end
        flush = 1'b0; rst_n = 1'b1;

`ifdef CDEMUX_STATS_EN
        // 17 beats on out1 wrap a 4-bit counter to 1
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        rst_n = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 64'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("stats_out1_wrap", 64'(out1_count), 64'd1);
        chk("stats_out0_zero", 64'(out0_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/complex_stream_demux.md
# complex_stream_demux

Routes a stream of 64-bit complex samples from one valid/ready input to one of two valid/ready outputs, selected per sample. It is the inverse of the complex 2:1 output mux in the datapath. It sits between the complex arithmetic core and the two downstream consumers. Each output has its own small FIFO, so a stalled consumer blocks only samples routed to it.

## Interface
Parameters:
- DEPTH, 2, entries per output FIFO; power of two, 2 to 16.
- CNT_W, 16, width of the statistics counters (present only with the macro).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of both FIFOs; data is discarded.
- in_data  in  64  sample, {re[31:0], im[31:0]}.
- in_sel  in  1  destination for in_data: 0 = out0, 1 = out1.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- out0_data / out1_data  out  64  head sample of each FIFO.
- out0_valid / out1_valid  out  1  FIFO non-empty.
- out0_ready / out1_ready  in  1  consumer accepts the head sample.
- out0_count / out1_count  out  CNT_W  delivered-beat counters (only with CDEMUX_STATS_EN).

## Operation
- in_ready = !full[in_sel] & !flush. It depends combinationally on in_sel, which is legal because in_sel is qualified by in_valid.
- Push: on a rising edge with in_valid & in_ready, in_data is written to FIFO[in_sel].
- Pop: on a rising edge with outK_valid & outK_ready, FIFO K advances.
- outK_data is the FIFO head when outK_valid = 1, and 64'h0 when outK_valid = 0.
- Samples are never reordered within an output. No ordering relation exists between out0 and out1.
- Simultaneous push and pop on the same FIFO:
  - not full: occupancy unchanged, both take effect;
  - full: in_ready = 0, so only the pop occurs. The full slot frees next cycle, not combinationally.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits. full = (occ == DEPTH); empty = (occ == 0).
- Data passes through bit-exact. There is no arithmetic on re or im.
- flush:
  - both FIFOs empty at the next edge;
  - in_ready = 0 while flush is high;
  - pops in the flush cycle are ignored (FIFO cleared regardless);
  - counters are not affected.
- If in_valid is low, in_sel and in_data are ignored.

## Timing
- Reset (rst_n = 0 at an edge): pointers and occupancy 0, out0_valid = out1_valid = 0, out0_data = out1_data = 0, counters 0. in_ready is 1 once rst_n is high and not flushing.
- Latency: a sample accepted at edge N is visible on outK_valid/outK_data in the cycle after edge N (1 cycle).
- Throughput: 1 sample per cycle while the target FIFO is not full.
- Reset asserted mid-stream: all in-flight samples are discarded. No output beat occurs on the reset edge.
- A consumer holding outK_ready = 0 stalls only inputs whose in_sel = K.

## Configuration
- CDEMUX_STATS_EN defined:
  - adds the out0_count and out1_count ports;
  - each is a CNT_W-bit counter incremented on every pop of its output;
  - counters wrap from all-ones to 0;
  - counters are reset by rst_n only.
- CDEMUX_STATS_EN undefined: the ports and counter logic are absent. Datapath behaviour is identical.

## Structure
- Shared package complex_pkg:
  - CPLX_W = 64, PART_W = 32;
  - typedef complex_t {re, im} (32 bits each);
  - helper functions to pack and unpack complex_t.
- One sub-module, complex_sync_fifo (parameter DEPTH, with flush), instantiated twice.
- The top level contains only routing, in_ready generation, and the optional counters.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 → both outK_valid = 0 and both data = 0. After release, in_ready = 1.
- Routing: push A = 64'h00000001_00000002 with sel = 0, then B = 64'h00000003_00000004 with sel = 1, both outputs ready → A appears on out0 and B on out1, each exactly 1 cycle after acceptance, no duplicates.
- Back-pressure isolation: DEPTH = 2, out0_ready = 0, push 3 samples with sel = 0 → in_ready drops after the 2nd. A sel = 1 sample is still accepted and delivered on out1.
- Full boundary: with FIFO0 full, raise out0_ready for 1 cycle → one pop. in_ready for sel = 0 returns the next cycle. FIFO order is preserved after the pointers wrap (push 5 samples through DEPTH = 2).
- Flush: FIFO0 holds 2 samples and FIFO1 holds 1, assert flush for 1 cycle → both outK_valid = 0 on the next cycle and in_ready = 0 during flush. A subsequent push is delivered normally.
- Stats (with CDEMUX_STATS_EN, CNT_W = 4): deliver 17 beats on out1 → out1_count = 1 (wrapped) and out0_count = 0.
